// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and dmem_responder.
// The misaligned flag exists only when DMEM_MISALIGN_TRAP_EN is defined.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_func3;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_func3,
      input  stall, rsp_valid, rsp_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
      , input misaligned
`endif
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_func3,
      output stall, rsp_valid, rsp_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
      , output misaligned
`endif
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency RV32I data memory: IDLE -> WAIT (LATENCY cycles) -> RESP.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q;
   logic [IDX_W+1:0]   addr_q;
   logic [31:0]        wdata_q;
   logic [2:0]         func3_q;
   logic [31:0]        rdata_q, rdata_d;
   logic               stall, rsp_valid, access, misalign, store_en;
   logic [31:0]        mem [DEPTH_WORDS];
   logic [IDX_W-1:0]   idx;
   logic [31:0]        word, load_data, store_data, store_word;
   logic [31:0]        byte_sh;
   logic [15:0]        half_sel;
   logic [3:0]         store_mask;

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall     = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               stall   = 1'b1;
               state_d = StWait;
               cnt_d   = 4'(LATENCY - 1);
            end
         end
         StWait: begin
            stall = 1'b1;
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            rsp_valid = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.stall     = stall;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rdata_q;

   assign access = (state_q == StWait) && (cnt_q == 4'd0);
   assign idx    = addr_q[IDX_W+1:2];
   assign word   = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
   always_comb begin
      unique case (func3_q)
         3'b001:  misalign = addr_q[0];
         3'b101:  misalign = !we_q && addr_q[0];
         3'b010:  misalign = |addr_q[1:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // Lane extraction; without trapping, addr[1] picks the half so addr[0] is ignored.
   assign byte_sh  = word >> {addr_q[1:0], 3'b000};
   assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

   always_comb begin
      unique case (func3_q)
         3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_data = word;
         3'b100:  load_data = {24'h0, byte_sh[7:0]};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = 32'h0;
      endcase
   end

   always_comb begin
      unique case (func3_q)
         3'b000: begin
            store_mask = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         3'b001: begin
            store_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata_q[15:0]}};
         end
         3'b010: begin
            store_mask = 4'b1111;
            store_data = wdata_q;
         end
         default: begin
            store_mask = 4'b0000;
            store_data = 32'h0;
         end
      endcase
      for (int b = 0; b < 4; b++) begin
         store_word[8*b +: 8] = store_mask[b] ? store_data[8*b +: 8] : word[8*b +: 8];
      end
   end

   // Reset in the access cycle must suppress the write.
   assign store_en = access && we_q && !misalign && !rst;

   always_comb begin
      rdata_d = rdata_q;
      if (access) rdata_d = (we_q || misalign) ? 32'h0 : load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (state_q == StIdle && bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[IDX_W+1:0];
            wdata_q <= bus.req_wdata;
            func3_q <= bus.req_func3;
         end
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned_q;

   always_ff @(posedge clk) begin
      if (rst) misaligned_q <= 1'b0;
      else     misaligned_q <= access && misalign;
   end

   assign bus.misaligned = misaligned_q;
`endif

   always_ff @(posedge clk) begin
      if (store_en) mem[idx] <= store_word;
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference memory.
// Honours DMEM_MISALIGN_TRAP_EN the same way as the design.
module tb_dmem_responder;
   localparam int unsigned DEPTH_WORDS = 256;
   localparam int unsigned LATENCY     = 2;
   localparam int unsigned NBYTES      = DEPTH_WORDS * 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0] model_mem [NBYTES];

   dmem_responder_if bus ();

   dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .LATENCY     (LATENCY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference behaviour from the access rules, little-endian byte array.
   task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, output logic [31:0] exp_rd,
                               output logic exp_mis);
      int unsigned base, size;
      logic [31:0] v;
      exp_rd  = 32'h0;
      exp_mis = 1'b0;
      base    = addr % NBYTES;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      if (size == 0 || (we && f3[2])) return;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (base % size != 0) begin
         exp_mis = 1'b1;
         return;
      end
`endif
      base = base - (base % size);
      if (we) begin
         for (int b = 0; b < int'(size); b++) model_mem[base + b] = wdata[8*b +: 8];
      end else begin
         v = 32'h0;
         for (int b = 0; b < int'(size); b++) v[8*b +: 8] = model_mem[base + b];
         if (!f3[2] && size == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
         if (!f3[2] && size == 2 && v[15]) v[31:16] = 16'hFFFF;
         exp_rd = v;
      end
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input string tag, output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic        exp_mis;
      int          stalls, lat;
      bit          seen;
      model_access(we, addr, wdata, f3, exp_rd, exp_mis);
      rd = 32'hx;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_func3 = f3;
      #1;
      stalls = bus.stall ? 1 : 0;
      seen   = 1'b0;
      lat    = 0;
      for (int c = 1; c <= int'(LATENCY) + 8 && !seen; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            seen = 1'b1;
            lat  = c;
            rd   = bus.rsp_rdata;
            check_eq({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
            check_eq({tag, "_stall_resp"}, 32'(bus.stall), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
            check_eq({tag, "_mis"}, 32'(bus.misaligned), 32'(exp_mis));
`endif
            bus.req_valid = 1'b0;
         end else if (bus.stall) begin
            stalls++;
         end
      end
      bus.req_valid = 1'b0;
      check_eq({tag, "_latency"}, 32'(lat), 32'(LATENCY + 1));
      check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(LATENCY + 1));
      @(negedge clk);
      check_eq({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
      check_eq({tag, "_idle_stall"}, 32'(bus.stall), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, prior, a, d;
      logic [2:0]  f3;
      logic        we;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.req_func3 = 3'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_eq("reset_stall", 32'(bus.stall), 32'd0);
      check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("reset_rdata", bus.rsp_rdata, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      check_eq("reset_mis", 32'(bus.misaligned), 32'd0);
`endif

      // Give every word a known value so random loads are fully predictable.
      for (int i = 0; i < int'(DEPTH_WORDS); i++) do_access(1'b1, 32'(i * 4), $urandom, 3'b010, "init", rd);

      do_access(1'b1, 32'h40, 32'hDEADBEEF, 3'b010, "sw_40", rd);
      check_eq("sw_rdata_zero", rd, 32'h0);
      do_access(1'b0, 32'h40, 32'h0, 3'b010, "lw_40", rd);
      check_eq("lw_deadbeef", rd, 32'hDEADBEEF);
      do_access(1'b0, 32'h43, 32'h0, 3'b000, "lb_43", rd);
      check_eq("lb_43_val", rd, 32'hFFFFFFDE);
      do_access(1'b0, 32'h43, 32'h0, 3'b100, "lbu_43", rd);
      check_eq("lbu_43_val", rd, 32'h000000DE);
      do_access(1'b0, 32'h42, 32'h0, 3'b001, "lh_42", rd);
      check_eq("lh_42_val", rd, 32'hFFFFDEAD);
      do_access(1'b0, 32'h40, 32'h0, 3'b101, "lhu_40", rd);
      check_eq("lhu_40_val", rd, 32'h0000BEEF);
      do_access(1'b1, 32'h41, 32'h00000011, 3'b000, "sb_41", rd);
      do_access(1'b0, 32'h40, 32'h0, 3'b010, "lw_after_sb", rd);
      check_eq("sb_merge_val", rd, 32'hDEAD11EF);
      do_access(1'b1, 32'h40 + NBYTES, 32'h12345678, 3'b010, "sw_wrap", rd);
      do_access(1'b0, 32'h40, 32'h0, 3'b010, "lw_wrap", rd);
      check_eq("wrap_val", rd, 32'h12345678);
      do_access(1'b0, 32'h40, 32'h0, 3'b011, "illegal_f3", rd);
      check_eq("illegal_f3_val", rd, 32'h0);
      do_access(1'b0, 32'h42, 32'h0, 3'b010, "lw_42", rd);
`ifdef DMEM_MISALIGN_TRAP_EN
      check_eq("lw_42_trap_val", rd, 32'h0);
`else
      check_eq("lw_42_aligned_val", rd, 32'h12345678);
`endif

      // Store aborted by reset while waiting.
      do_access(1'b0, 32'h80, 32'h0, 3'b010, "lw_80_prior", prior);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h80;
      bus.req_wdata = 32'hAAAAAAAA;
      bus.req_func3 = 3'b010;
      @(negedge clk);
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_stall", 32'(bus.stall), 32'd0);
      check_eq("abort_rdata", bus.rsp_rdata, 32'h0);
      for (int c = 0; c < 6; c++) begin
         check_eq("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
         @(negedge clk);
      end
      do_access(1'b0, 32'h80, 32'h0, 3'b010, "lw_80_after", rd);
      check_eq("abort_mem_kept", rd, prior);

      for (int i = 0; i < 300; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 2 * NBYTES - 1));
         d  = $urandom;
         f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
            : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
         do_access(we, a, d, f3, $sformatf("rnd%0d", i), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end
endmodule
